wled_rx: RTL and testbench

- WS2812-style single-wire serial receiver, the inverse of the WS2812 LED driver path.
- Decodes an incoming GRB bit stream into 24-bit pixels and thresholds each colour byte into per-LED green/red/blue bits, which are updated once per completed frame.
- Used to let the board act as a pixel in an LED chain, or as a loopback monitor of the LED output.

---
 rtl/wled_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_wled_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wled_rx.sv
`default_nettype none
// ============================================================================
// Module   : wled_rx
// Purpose  : WS2812-style single-wire receiver. Decodes a GRB pulse stream
//            into 24-bit pixels, thresholds each colour byte into per-LED
//            green/red/blue bits and latches them once per frame.
// Option   : define WLED_RX_PASSTHRU_EN to forward the pulses that follow
//            this device's NUM_LEDS pixels on data_out (chain mode).
// Revision : 1.0 - initial release
// ============================================================================
module wled_rx #(
    parameter int CLK_MHZ   = 27,
    parameter int NUM_LEDS  = 1,
    parameter int THRESHOLD = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_in,
    output logic [NUM_LEDS-1:0] green,
    output logic [NUM_LEDS-1:0] red,
    output logic [NUM_LEDS-1:0] blue,
    output logic [23:0]         rgb_data,
    output logic                pixel_valid,
    output logic [7:0]          pixel_index,
    output logic                frame_done,
    output logic                error,
    output logic                data_out
);

    localparam int C_BIT_THR   = CLK_MHZ * 600 / 1000;
    localparam int C_MAX_HIGH  = CLK_MHZ * 2;
    localparam int C_RESET_CYC = CLK_MHZ * 50;
    localparam int C_LW        = $clog2(C_RESET_CYC + 1);
    localparam int C_HW        = $clog2(C_MAX_HIGH + 1);

    localparam logic [C_LW-1:0] C_LOW_LAST  = C_LW'(C_RESET_CYC - 1);
    localparam logic [C_LW-1:0] C_LOW_SAT   = C_LW'(C_RESET_CYC);
    localparam logic [C_HW-1:0] C_HIGH_LAST = C_HW'(C_MAX_HIGH - 1);
    localparam logic [C_HW-1:0] C_BIT_THR_V = C_HW'(C_BIT_THR);
    localparam logic [7:0]      C_THR       = 8'(THRESHOLD);
`ifdef WLED_RX_PASSTHRU_EN
    localparam logic [7:0]      C_LAST_LED  = 8'(NUM_LEDS - 1);
`endif

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t              state_q;
    logic                sync1_q;
    logic                data_s_q;
    logic                data_prev_q;
    logic [C_LW-1:0]     low_cnt_q;
    logic [C_HW-1:0]     high_cnt_q;
    logic [22:0]         shift_q;
    logic [4:0]          bit_cnt_q;
    logic [7:0]          led_idx_q;
    logic                err_frame_q;
    logic [NUM_LEDS-1:0] sh_g_q;
    logic [NUM_LEDS-1:0] sh_r_q;
    logic [NUM_LEDS-1:0] sh_b_q;
`ifdef WLED_RX_PASSTHRU_EN
    logic                fwd_en_q;
    logic                data_out_q;
`endif

    logic        data_rise;
    logic        data_fall;
    logic        bit_val;
    logic [23:0] shift_d;

    assign data_rise = data_s_q & ~data_prev_q;
    assign data_fall = ~data_s_q & data_prev_q;
    // A pulse is a '1' when it stayed high past the bit threshold.
    assign bit_val   = (high_cnt_q > C_BIT_THR_V);
    assign shift_d   = {shift_q, bit_val};

    // Two-flop synchroniser for the asynchronous line plus an edge-detect tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            data_s_q    <= 1'b0;
            data_prev_q <= 1'b0;
        end else begin
            sync1_q     <= data_in;
            data_s_q    <= sync1_q;
            data_prev_q <= data_s_q;
        end
    end

    // Pulse decoder, pixel assembly, shadow update and frame latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            low_cnt_q   <= '0;
            high_cnt_q  <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            led_idx_q   <= '0;
            err_frame_q <= 1'b0;
            sh_g_q      <= '0;
            sh_r_q      <= '0;
            sh_b_q      <= '0;
            green       <= '0;
            red         <= '0;
            blue        <= '0;
            rgb_data    <= '0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
`ifdef WLED_RX_PASSTHRU_EN
            fwd_en_q    <= 1'b0;
`endif
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            case (state_q)
                ST_SYNC: begin
`ifdef WLED_RX_PASSTHRU_EN
                    fwd_en_q <= 1'b0;
`endif
                    if (data_s_q) begin
                        low_cnt_q <= '0;
                    end else if (low_cnt_q == C_LOW_LAST) begin
                        // The gap is already counted: park the low counter
                        // saturated so only a real frame can end later.
                        state_q     <= ST_LOW;
                        low_cnt_q   <= C_LOW_SAT;
                        bit_cnt_q   <= '0;
                        led_idx_q   <= '0;
                        err_frame_q <= 1'b0;
                    end else begin
                        low_cnt_q <= low_cnt_q + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (data_rise) begin
                        high_cnt_q <= '0;
                        state_q    <= ST_HIGH;
                    end else if (low_cnt_q == C_LOW_LAST) begin
                        green       <= sh_g_q;
                        red         <= sh_r_q;
                        blue        <= sh_b_q;
                        frame_done  <= 1'b1;
                        low_cnt_q   <= C_LOW_SAT;
                        bit_cnt_q   <= '0;
                        led_idx_q   <= '0;
                        err_frame_q <= 1'b0;
`ifdef WLED_RX_PASSTHRU_EN
                        fwd_en_q    <= 1'b0;
`endif
                        if (bit_cnt_q != 5'd0) begin
                            error <= 1'b1;
                        end else if (!err_frame_q) begin
                            error <= 1'b0;
                        end
                    end else if (low_cnt_q != C_LOW_SAT) begin
                        low_cnt_q <= low_cnt_q + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (data_fall) begin
                        // The cycle that shows the fall is already low.
                        low_cnt_q <= C_LW'(1);
                        state_q   <= ST_LOW;
                        shift_q   <= shift_d[22:0];
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_q   <= '0;
                            rgb_data    <= shift_d;
                            pixel_index <= led_idx_q;
                            pixel_valid <= 1'b1;
                            for (int i = 0; i < NUM_LEDS; i++) begin
                                if (led_idx_q == 8'(i)) begin
                                    sh_g_q[i] <= (shift_d[23:16] >= C_THR);
                                    sh_r_q[i] <= (shift_d[15:8]  >= C_THR);
                                    sh_b_q[i] <= (shift_d[7:0]   >= C_THR);
                                end
                            end
                            if (led_idx_q != 8'hFF) begin
                                led_idx_q <= led_idx_q + 1'b1;
                            end
`ifdef WLED_RX_PASSTHRU_EN
                            if (led_idx_q == C_LAST_LED) begin
                                fwd_en_q <= 1'b1;
                            end
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else if (high_cnt_q == C_HIGH_LAST) begin
                        // Line stuck high: drop the partial pixel and resync.
                        error       <= 1'b1;
                        err_frame_q <= 1'b1;
                        bit_cnt_q   <= '0;
                        low_cnt_q   <= '0;
                        state_q     <= ST_SYNC;
                    end else begin
                        high_cnt_q <= high_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_SYNC;
                end
            endcase
        end
    end

`ifdef WLED_RX_PASSTHRU_EN
    // Forward the synchronised line once our own pixels have been consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= 1'b0;
        end else begin
            data_out_q <= data_s_q & fwd_en_q;
        end
    end

    assign data_out = data_out_q;
`else
    assign data_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wled_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_wled_rx
// Purpose  : Self-checking bench for wled_rx (NUM_LEDS=2). Random pulse
//            widths and pixel values are compared against a frame-level
//            reference model of the expected pixels and LED bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wled_rx;

    localparam int NL  = 2;
    localparam int THR = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_in = 1'b0;
    logic [NL-1:0] green;
    logic [NL-1:0] red;
    logic [NL-1:0] blue;
    logic [23:0]   rgb_data;
    logic          pixel_valid;
    logic [7:0]    pixel_index;
    logic          frame_done;
    logic          error;
    logic          data_out;

    wled_rx #(
        .CLK_MHZ   (27),
        .NUM_LEDS  (NL),
        .THRESHOLD (THR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .green       (green),
        .red         (red),
        .blue        (blue),
        .rgb_data    (rgb_data),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .error       (error),
        .data_out    (data_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observed activity
    logic [31:0] pv_q[$];
    int          fd_cnt   = 0;
    int          dout_bad = 0;
    logic        fwd_win  = 1'b0;
    logic        h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
    logic        exp_do;

    // Reference model
    logic [31:0]   exp_q[$];
    int            m_idx = 0;
    bit            m_bad = 1'b0;
    logic [NL-1:0] sh_g = '0, sh_r = '0, sh_b = '0;
    logic [NL-1:0] o_g = '0, o_r = '0, o_b = '0;
    logic          m_err = 1'b0;
    logic [23:0]   rp;

    // History of the line as seen at each clock edge.
    always @(posedge clk) begin
        h2 = h1;
        h1 = h0;
        h0 = data_in;
    end

    // Collect strobes and compare the forwarded line every cycle.
    always @(negedge clk) begin
        if (pixel_valid) pv_q.push_back({pixel_index, rgb_data});
        if (frame_done) fd_cnt++;
`ifdef WLED_RX_PASSTHRU_EN
        exp_do = fwd_win & h2;
`else
        exp_do = 1'b0;
`endif
        if (data_out !== exp_do) dout_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n, input logic v);
        data_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_bit(input logic b);
        int hi;
        int lo;
        hi = b ? int'($urandom_range(30, 19)) : int'($urandom_range(14, 5));
        lo = int'($urandom_range(25, 12));
        idle(hi, 1'b1);
        idle(lo, 1'b0);
    endtask

    task automatic tx_pixel(input logic [23:0] p);
        int gv, rv, bv;
        for (int i = 23; i >= 0; i--) tx_bit(p[i]);
        exp_q.push_back({8'(m_idx), p});
        gv = int'(p[23:16]);
        rv = int'(p[15:8]);
        bv = int'(p[7:0]);
        if (m_idx < NL) begin
            sh_g[m_idx] = (gv >= THR);
            sh_r[m_idx] = (rv >= THR);
            sh_b[m_idx] = (bv >= THR);
        end
        if (m_idx < 255) m_idx++;
    endtask

    task automatic tx_bits(input int n);
        for (int i = 0; i < n; i++) tx_bit(1'($urandom_range(1, 0)));
        m_bad = 1'b1;
    endtask

    task automatic begin_frame();
        pv_q.delete();
        exp_q.delete();
        fd_cnt   = 0;
        dout_bad = 0;
        m_idx    = 0;
        m_bad    = 1'b0;
    endtask

    task automatic end_frame(input string tag);
        idle(1400, 1'b0);
        o_g   = sh_g;
        o_r   = sh_r;
        o_b   = sh_b;
        m_err = m_bad;
        chk({tag, ".pixel_count"}, 32'(pv_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < pv_q.size(); i++)
            chk({tag, ".pixel"}, pv_q[i], exp_q[i]);
        chk({tag, ".frame_done_count"}, 32'(fd_cnt), 32'd1);
        chk({tag, ".green"}, 32'(green), 32'(o_g));
        chk({tag, ".red"},   32'(red),   32'(o_r));
        chk({tag, ".blue"},  32'(blue),  32'(o_b));
        chk({tag, ".error"}, 32'(error), 32'(m_err));
        chk({tag, ".data_out_bad_cycles"}, 32'(dout_bad), 32'd0);
        fwd_win = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".green"},       32'(green),       32'd0);
        chk({tag, ".red"},         32'(red),         32'd0);
        chk({tag, ".blue"},        32'(blue),        32'd0);
        chk({tag, ".rgb_data"},    32'(rgb_data),    32'd0);
        chk({tag, ".pixel_index"}, 32'(pixel_index), 32'd0);
        chk({tag, ".pixel_valid"}, 32'(pixel_valid), 32'd0);
        chk({tag, ".frame_done"},  32'(frame_done),  32'd0);
        chk({tag, ".error"},       32'(error),       32'd0);
        chk({tag, ".data_out"},    32'(data_out),    32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        data_in = 1'b0;
        repeat (4) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        idle(1400, 1'b0);

        // Basic decode with fixed pixels
        begin_frame();
        tx_pixel(24'hFF0000);
        tx_pixel(24'h00FF80);
        end_frame("basic");

        // Threshold boundary: 0x7F below, 0x80 at threshold
        begin_frame();
        tx_pixel(24'h7F7F7F);
        tx_pixel(24'h808080);
        end_frame("threshold");

        // Extra pixel beyond NUM_LEDS, forwarded in chain mode
        begin_frame();
        rp = 24'($urandom); tx_pixel(rp);
        rp = 24'($urandom); tx_pixel(rp);
        fwd_win = 1'b1;
        tx_pixel(24'hFFFFFF);
        end_frame("extra_pixel");

        // Partial pixel then gap: error, outputs retained
        begin_frame();
        tx_bits(10);
        end_frame("partial");

        // Clean frame clears the error
        begin_frame();
        rp = 24'($urandom); tx_pixel(rp);
        rp = 24'($urandom); tx_pixel(rp);
        end_frame("recover");

        // Stuck-high pulse: error, resync on gap without frame_done
        begin_frame();
        idle(60, 1'b1);
        idle(15, 1'b0);
        m_err = 1'b1;
        chk("timeout.error", 32'(error), 32'(m_err));
        idle(1400, 1'b0);
        chk("timeout.frame_done_count", 32'(fd_cnt), 32'd0);
        chk("timeout.pixel_count", 32'(pv_q.size()), 32'd0);
        chk("timeout.data_out_bad_cycles", 32'(dout_bad), 32'd0);
        begin_frame();
        rp = 24'($urandom); tx_pixel(rp);
        rp = 24'($urandom); tx_pixel(rp);
        end_frame("after_timeout");

        // Reset mid-pixel, then pulses without a gap are ignored
        begin_frame();
        tx_bits(12);
        rst = 1'b1;
        idle(2, 1'b0);
        rst = 1'b0;
        sh_g = '0; sh_r = '0; sh_b = '0;
        chk_zero("mid_reset");
        pv_q.delete();
        fd_cnt = 0;
        tx_bits(12);
        idle(100, 1'b0);
        chk("mid_reset.ignored_pixels", 32'(pv_q.size()), 32'd0);
        chk("mid_reset.ignored_frame_done", 32'(fd_cnt), 32'd0);
        idle(1400, 1'b0);
        begin_frame();
        rp = 24'($urandom); tx_pixel(rp);
        rp = 24'($urandom); tx_pixel(rp);
        end_frame("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
